mips_trace_buffer: RTL and testbench
====================================

// Module: mips_trace_buffer
// PURPOSE
//  On-chip trace capture for the MIPS core, fed by the mips_debug_wrapper taps (pc, instr, mem_*).
//  Records retired-instruction / memory-access events into a circular RAM with a PC-match trigger
//  and a programmable post-trigger window. After capture, replays entries oldest-first over a
//  valid/ready port, so silicon and FPGA builds get the same trace the simulation $monitor gives.
// PARAMETERS
//  XLEN       32  width of pc/instr/addr/data fields
//  DEPTH      16  entries in trace RAM; power of two, >=4
//  POST_TRIG  4   entries captured after the trigger entry; clamped internally to DEPTH-1
//  PTR_W      $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk        in   1        core clock; all logic on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  arm        in   1        pulse: IDLE->ARMED, starts capture
//  clear      in   1        pulse: abort/flush from any state to IDLE; priority over arm
//  mode       in   1        0 = capture every retired instr, 1 = capture only mem_we=1 events
//  trig_en    in   1        1 = PC-match trigger active; 0 = fill DEPTH entries then stop
//  trig_pc    in   XLEN     trigger PC value
//  ev_valid   in   1        retire strobe for current pc/instr/mem_* sample
//  pc         in   XLEN     retired PC
//  instr      in   XLEN     retired instruction word
//  mem_we     in   1        data-memory write enable of retired instr
//  mem_addr   in   XLEN     data-memory address
//  mem_wd     in   XLEN     data-memory write data
//  rd_ready   in   1        readout sink ready
//  rd_valid   out  1        rd_data holds an unread entry
//  rd_data    out  3*XLEN+1+XLEN  entry {mem_we, pc, instr, mem_addr, mem_wd}, mem_we is MSB
//  state      out  2        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  count      out  PTR_W+1  valid entries stored (0..DEPTH); decrements during readout
//  triggered  out  1        trigger has fired in this capture
//  overflow   out  1        ARMED wrapped; oldest entries were overwritten
// BEHAVIOUR
//  Reset: state=IDLE, count=0, wr_ptr=rd_ptr=0, rd_valid=0, rd_data=0, triggered=0, overflow=0.
//  Capture event = ev_valid && (mode==0 || mem_we) && state in {ARMED,POST}.
//  The entry is written to RAM[wr_ptr] in the same cycle. wr_ptr wraps DEPTH-1 -> 0.
//  IDLE: arm (and !clear) -> ARMED; clears count/ptrs/triggered/overflow on entry.
//  ARMED, trig_en=1: on a capture with pc==trig_pc, that entry is stored, triggered<=1, post_cnt<=0,
//   -> POST. If the trigger hit is not a capture event (filtered by mode), it still fires; POST then
//   waits for POST_TRIG captures. Wrap at count==DEPTH: oldest entry overwritten, rd_ptr advances
//   with wr_ptr, count holds DEPTH, overflow<=1.
//  ARMED, trig_en=0: no wrap; on the capture that makes count==DEPTH -> DONE.
//  POST: each capture increments post_cnt. The capture with post_cnt==POST_TRIG-1 -> DONE.
//   POST_TRIG==0 goes to DONE directly from ARMED on the trigger entry. Wrap rules match ARMED.
//  DONE: capture frozen. ev_valid ignored. rd_ptr = oldest entry.
//  Readout: 1-cycle registered RAM read. rd_valid rises one cycle after entering DONE when count>0.
//   Handshake when rd_valid&&rd_ready. Then rd_ptr++, count--, rd_valid=0 for one cycle (bubble),
//   then the next entry is presented. Throughput is 1 entry per 2 cycles. rd_data is stable while
//   rd_valid&&!rd_ready.
//   After the last handshake (count 1->0), go to IDLE next cycle. triggered/overflow hold until the
//   next arm or clear.
//  clear in any state -> IDLE next edge, count=0, rd_valid=0, flags=0; any in-flight read is dropped.
//  arm outside IDLE is ignored. Simultaneous arm+clear = clear.
//  Async rst_n mid-capture/readout: immediate return to reset values. RAM contents are don't-care.
// TESTING (DEPTH=8, POST_TRIG=2 unless noted)
//  1 reset: rst_n=0 mid-POST -> state=0,count=0,rd_valid=0 immediately, before the next clk edge.
//  2 trigger: arm, trig_en=1, trig_pc=0x20, retire pc 0x00..0x30 step 4 -> DONE after pc 0x28.
//    Readout gives 8 entries pc 0x0C..0x28, triggered=1, overflow=1.
//  3 no trigger: trig_en=0, retire pc 0x00..0x40 -> DONE at count=8; readout gives pc 0x00..0x1C,
//    overflow=0.
//  4 mode=1: 10 instrs with mem_we on pc 0x08,0x14,0x24 only, trig_en=0 -> count=3, not DONE;
//    entries hold exact addr/wd.
//  5 backpressure: in DONE hold rd_ready=0 for 5 cycles -> rd_data stable, rd_valid=1;
//    then pulse rd_ready per entry -> 2-cycle spacing, IDLE after the last.
//  6 clear+arm same cycle during POST -> IDLE, count=0; trigger at first ARMED capture with
//    POST_TRIG=0 -> DONE, count=1.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// Circular trace RAM for retired MIPS instructions with PC trigger,
// post-trigger window and oldest-first valid/ready replay.
module mips_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              clear,
    input  logic              mode,
    input  logic              trig_en,
    input  logic [XLEN-1:0]   trig_pc,
    input  logic              ev_valid,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   instr,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wd,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [4*XLEN:0]   rd_data,
    output logic [1:0]        state,
    output logic [PTR_W:0]    count,
    output logic              triggered,
    output logic              overflow
);

    localparam int PT = (POST_TRIG > DEPTH - 1) ? DEPTH - 1 : POST_TRIG;
    localparam int EW = 4 * XLEN + 1;
    localparam logic [PTR_W-1:0] PT_LAST = PTR_W'((PT == 0) ? 0 : PT - 1);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] NEAR = (PTR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  post_q, post_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              trig_q, trig_d;
    logic              ovf_q, ovf_d;
    logic              rv_q, rv_d;
    logic [EW-1:0]     rdat_q, rdat_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic cap, hit, full, hs, we;

    always_comb begin
        cap = ev_valid && (!mode || mem_we)
              && (state_q == S_ARMED || state_q == S_POST);
        hit = (state_q == S_ARMED) && trig_en && ev_valid && (pc == trig_pc);
        full = (count_q == FULL);
        hs = rv_q && rd_ready;
        we = 1'b0;
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        post_d   = post_q;
        count_d  = count_q;
        trig_d   = trig_q;
        ovf_d    = ovf_q;
        rv_d     = rv_q;
        rdat_d   = rdat_q;
        if (clear) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            post_d   = '0;
            count_d  = '0;
            trig_d   = 1'b0;
            ovf_d    = 1'b0;
            rv_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d  = S_ARMED;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        post_d   = '0;
                        count_d  = '0;
                        trig_d   = 1'b0;
                        ovf_d    = 1'b0;
                        rv_d     = 1'b0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (cap) begin
                        we = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // Full ring: drop the oldest entry to make room
                        if (full) begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (state_q == S_ARMED) begin
                        if (hit) begin
                            trig_d  = 1'b1;
                            post_d  = '0;
                            state_d = (PT == 0) ? S_DONE : S_POST;
                        end else if (!trig_en && cap && count_q >= NEAR) begin
                            state_d = S_DONE;
                        end
                    end else if (cap) begin
                        post_d = post_q + 1'b1;
                        if (post_q == PT_LAST) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (hs) begin
                        rv_d     = 1'b0;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                        if (count_q == 1) state_d = S_IDLE;
                    end else if (!rv_q) begin
                        if (count_q != 0) begin
                            rv_d   = 1'b1;
                            rdat_d = mem_q[rd_ptr_q];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            post_q   <= '0;
            count_q  <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rv_q     <= 1'b0;
            rdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            post_q   <= post_d;
            count_q  <= count_d;
            trig_q   <= trig_d;
            ovf_q    <= ovf_d;
            rv_q     <= rv_d;
            rdat_q   <= rdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q] <= {mem_we, pc, instr, mem_addr, mem_wd};
    end

    assign rd_valid  = rv_q;
    assign rd_data   = rdat_q;
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = trig_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: DEPTH=8 with POST_TRIG=2 and POST_TRIG=0
// instances sharing stimulus; readout compared against a scoreboard queue.
module tb_mips_trace_buffer;

    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst_n, arm, clear, mode, trig_en, ev_valid, mem_we, rd_ready;
    logic [XL-1:0] trig_pc, pc, instr, mem_addr, mem_wd;

    logic          rd_valid, triggered, overflow;
    logic [4*XL:0] rd_data;
    logic [1:0]    state;
    logic [3:0]    count;

    logic          z_rd_valid, z_triggered, z_overflow;
    logic [4*XL:0] z_rd_data;
    logic [1:0]    z_state;
    logic [3:0]    z_count;

    int n_chk = 0;
    int n_err = 0;
    logic [4*XL:0] sb[$];

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          exp_cnt;
    } vec_t;
    vec_t tv[10];

    always #5 clk = ~clk;

    mips_trace_buffer #(.XLEN(XL), .DEPTH(8), .POST_TRIG(2)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .mode(mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .ev_valid(ev_valid), .pc(pc),
        .instr(instr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .state(state), .count(count), .triggered(triggered), .overflow(overflow)
    );

    mips_trace_buffer #(.XLEN(XL), .DEPTH(8), .POST_TRIG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .mode(mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .ev_valid(ev_valid), .pc(pc),
        .instr(instr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .rd_ready(rd_ready), .rd_valid(z_rd_valid), .rd_data(z_rd_data),
        .state(z_state), .count(z_count), .triggered(z_triggered),
        .overflow(z_overflow)
    );

    function automatic logic [31:0] ins(input logic [31:0] p);
        return p ^ 32'h2400_A5A5;
    endfunction

    function automatic logic [4*XL:0] ent(input logic w, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] d);
        return {w, p, ins(p), a, d};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [4*XL:0] act,
                        input logic [4*XL:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic ev(input logic [31:0] p, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
        ev_valid = 1'b1;
        pc = p;
        instr = ins(p);
        mem_we = w;
        mem_addr = a;
        mem_wd = d;
        @(negedge clk);
        ev_valid = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic drain(input int n, input string nm);
        int w;
        logic [4*XL:0] e;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                w = 0;
                while (!rd_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
            end
            chk({nm, " rd_valid"}, int'(rd_valid), 1);
            if (!rd_valid) return;
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chkd({nm, " rd_data"}, rd_data, e);
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            chk({nm, " count dec"}, int'(count), n - 1 - k);
            if (k == n - 1) begin
                chk({nm, " idle after last"}, int'(state), 0);
            end else begin
                chk({nm, " bubble"}, int'(rd_valid), 0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        tv[0] = '{32'h00, 1'b0, 32'h0, 32'h0, 0};
        tv[1] = '{32'h04, 1'b0, 32'h0, 32'h0, 0};
        tv[2] = '{32'h08, 1'b1, 32'h1000_0010, 32'hDEAD_0001, 1};
        tv[3] = '{32'h0C, 1'b0, 32'h0, 32'h0, 1};
        tv[4] = '{32'h10, 1'b0, 32'h0, 32'h0, 1};
        tv[5] = '{32'h14, 1'b1, 32'h1000_0024, 32'hBEEF_0002, 2};
        tv[6] = '{32'h18, 1'b0, 32'h0, 32'h0, 2};
        tv[7] = '{32'h1C, 1'b0, 32'h0, 32'h0, 2};
        tv[8] = '{32'h20, 1'b0, 32'h0, 32'h0, 2};
        tv[9] = '{32'h24, 1'b1, 32'h1000_0038, 32'hCAFE_0003, 3};

        rst_n = 1'b0; arm = 1'b0; clear = 1'b0; mode = 1'b0; trig_en = 1'b0;
        trig_pc = '0; ev_valid = 1'b0; pc = '0; instr = '0; mem_we = 1'b0;
        mem_addr = '0; mem_wd = '0; rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst state", int'(state), 0);
        chk("rst count", int'(count), 0);
        chk("rst rd_valid", int'(rd_valid), 0);
        chkd("rst rd_data", rd_data, '0);
        chk("rst flags", int'({triggered, overflow}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // PC trigger with wrap and post window
        trig_en = 1'b1;
        trig_pc = 32'h20;
        pulse_arm();
        chk("t2 armed", int'(state), 1);
        for (int p = 0; p <= 'h30; p += 4) begin
            ev(32'(p), 1'b0, 32'(p) + 32'h100, ~32'(p));
            if (p <= 'h28) sb.push_back(ent(1'b0, 32'(p), 32'(p) + 32'h100, ~32'(p)));
            while (sb.size() > 8) void'(sb.pop_front());
        end
        chk("t2 done", int'(state), 3);
        chk("t2 count", int'(count), 8);
        chk("t2 triggered", int'(triggered), 1);
        chk("t2 overflow", int'(overflow), 1);
        drain(8, "t2");
        chk("t2 flags hold", int'({triggered, overflow}), 3);

        // no trigger: fill then stop
        trig_en = 1'b0;
        pulse_arm();
        chk("t3 flags cleared", int'({triggered, overflow}), 0);
        for (int p = 0; p <= 'h40; p += 4) begin
            ev(32'(p), 1'b0, 32'(p) + 32'h200, 32'(p) * 3);
            if (p <= 'h1C) sb.push_back(ent(1'b0, 32'(p), 32'(p) + 32'h200, 32'(p) * 3));
        end
        chk("t3 done", int'(state), 3);
        chk("t3 count", int'(count), 8);
        chk("t3 overflow", int'(overflow), 0);
        drain(8, "t3");

        // mode=1 store filter from a table
        sb.delete();
        mode = 1'b1;
        pulse_arm();
        foreach (tv[i]) begin
            ev(tv[i].pc, tv[i].we, tv[i].addr, tv[i].wd);
            if (tv[i].we) sb.push_back(ent(1'b1, tv[i].pc, tv[i].addr, tv[i].wd));
            chk($sformatf("t4 count[%0d]", i), int'(count), tv[i].exp_cnt);
        end
        chk("t4 still armed", int'(state), 1);
        for (int i = 0; i < 5; i++) begin
            ev(32'h100 + 32'(4 * i), 1'b1, 32'h2000 + 32'(i), 32'(i * 7));
            sb.push_back(ent(1'b1, 32'h100 + 32'(4 * i), 32'h2000 + 32'(i), 32'(i * 7)));
        end
        chk("t4 done", int'(state), 3);

        // backpressure in DONE
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5 hold valid[%0d]", i), int'(rd_valid), 1);
            chkd($sformatf("t5 hold data[%0d]", i), rd_data, sb[0]);
            @(negedge clk);
        end
        drain(8, "t5");
        mode = 1'b0;

        // clear+arm during POST, then POST_TRIG=0 trigger on first capture
        sb.delete();
        trig_en = 1'b1;
        trig_pc = 32'h50;
        pulse_arm();
        ev(32'h4C, 1'b0, 32'h0, 32'h0);
        ev(32'h50, 1'b0, 32'h0, 32'h0);
        chk("t6 post", int'(state), 2);
        clear = 1'b1;
        arm = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        arm = 1'b0;
        chk("t6 clear wins", int'(state), 0);
        chk("t6 count", int'(count), 0);
        chk("t6 trig cleared", int'(triggered), 0);
        chk("t6 dut0 idle", int'(z_state), 0);
        pulse_arm();
        ev(32'h50, 1'b0, 32'h3000, 32'h1234_5678);
        chk("t6 dut0 done", int'(z_state), 3);
        chk("t6 dut0 count", int'(z_count), 1);
        chk("t6 dut0 trig", int'(z_triggered), 1);
        @(negedge clk);
        chk("t6 dut0 valid", int'(z_rd_valid), 1);
        chkd("t6 dut0 data", z_rd_data, ent(1'b0, 32'h50, 32'h3000, 32'h1234_5678));

        // async reset mid-POST
        chk("t1 in post", int'(state), 2);
        rst_n = 1'b0;
        #1;
        chk("t1 async state", int'(state), 0);
        chk("t1 async count", int'(count), 0);
        chk("t1 async rd_valid", int'(z_rd_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
